// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target responder.
// Bus event bundle passed from the sampler to the protocol FSM.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_HOLD
  } state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef struct packed {
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
  } bus_ev_t;

  function automatic logic [7:0] shift_in(
    input logic [7:0] s,
    input logic       b
  );
    return {s[6:0], b};
  endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// Synchronises SCL/SDA and derives edge and START/STOP pulses.
// Sync flops preset high so an idle bus produces no spurious edges.
module i2c_bus_sampler
  import i2c_target_pkg::*;
(
  input  logic    pclk,
  input  logic    areset,
  input  logic    scl_i,
  input  logic    sda_i,
  output bus_ev_t ev_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_dly_q;
  logic       sda_dly_q;
  logic       scl_s;
  logic       sda_s;

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign ev_o.sda      = sda_s;
  assign ev_o.scl_rise = scl_s & ~scl_dly_q;
  assign ev_o.scl_fall = ~scl_s & scl_dly_q;
  assign ev_o.start    = scl_s & scl_dly_q
                       & sda_dly_q & ~sda_s;
  assign ev_o.stop     = scl_s & scl_dly_q
                       & ~sda_dly_q & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target endpoint: address match, pointer/data writes,
// pointer-based reads onto a byte-wide register bus.
module i2c_target_responder
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned REG_AW      = 4
) (
  input  logic              pclk,
  input  logic              areset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_o,
  output logic              scl_oen,
  output logic              sda_o,
  output logic              sda_oen,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  bus_ev_t ev;

  i2c_bus_sampler u_sampler (
    .pclk   (pclk),
    .areset (areset),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .ev_o   (ev)
  );

  state_e            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              rw_q, rw_d;
  logic              first_wr_q, first_wr_d;
  logic              ack_drv_q, ack_drv_d;
  logic              done_q, done_d;
  logic              load_q, load_d;
  logic              load_drv_q, load_drv_d;
  logic              oen_q, oen_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic [7:0]        byte_in;
  logic              last_bit;

  assign byte_in  = shift_in(shift_q, ev.sda);
  assign last_bit = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rw_d       = rw_q;
    first_wr_d = first_wr_q;
    ack_drv_d  = ack_drv_q;
    done_d     = done_q;
    load_d     = 1'b0;
    load_drv_d = 1'b0;
    oen_d      = oen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    busy_d     = busy_q;

    // pointer advances the cycle after the write strobe
    if (wr_q) begin
      addr_d = addr_q + 1'b1;
    end
    if (load_q) begin
      shift_d = reg_rdata;
      if (load_drv_q) begin
        oen_d = ~reg_rdata[7];
      end
    end

    if (ev.start) begin
      state_d   = ST_ADDR;
      busy_d    = 1'b1;
      oen_d     = 1'b0;
      ack_drv_d = 1'b0;
      done_d    = 1'b0;
    end else if (ev.stop) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      oen_d     = 1'b0;
      ack_drv_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (ev.scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (byte_in[7:1] == TARGET_ADDR) begin
                state_d    = ST_ADDR_ACK;
                rw_d       = byte_in[0] ? RW_READ
                                        : RW_WRITE;
                first_wr_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (ev.scl_fall) begin
            if (!ack_drv_q) begin
              oen_d     = ~ACK;
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              if (state_q == ST_ADDR_ACK &&
                  rw_q == RW_READ) begin
                rd_d       = 1'b1;
                load_d     = 1'b1;
                load_drv_d = 1'b1;
                state_d    = ST_RD_BYTE;
              end else begin
                oen_d   = 1'b0;
                state_d = ST_WR_BYTE;
              end
            end
          end
        end
        ST_WR_BYTE: begin
          if (ev.scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              state_d = ST_WR_ACK;
              if (first_wr_q) begin
                addr_d     = byte_in[REG_AW-1:0];
                first_wr_d = 1'b0;
              end else begin
                wdata_d = byte_in;
                wr_d    = 1'b1;
              end
            end
          end
        end
        ST_RD_BYTE: begin
          if (ev.scl_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              done_d = 1'b1;
            end
          end else if (ev.scl_fall) begin
            if (done_q) begin
              done_d  = 1'b0;
              oen_d   = 1'b0;
              addr_d  = addr_q + 1'b1;
              state_d = ST_RD_ACK;
            end else begin
              oen_d = ~shift_q[7];
            end
          end
        end
        ST_RD_ACK: begin
          if (ev.scl_rise) begin
            if (ev.sda == NACK) begin
              state_d = ST_HOLD;
            end else begin
              rd_d    = 1'b1;
              load_d  = 1'b1;
              state_d = ST_RD_BYTE;
            end
          end
        end
        ST_IDLE, ST_HOLD: ;
        default: ;
      endcase
    end

    if (ev.start || state_d != state_q) begin
      bit_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rw_q       <= RW_WRITE;
      first_wr_q <= 1'b0;
      ack_drv_q  <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
      load_drv_q <= 1'b0;
      oen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rw_q       <= rw_d;
      first_wr_q <= first_wr_d;
      ack_drv_q  <= ack_drv_d;
      done_q     <= done_d;
      load_q     <= load_d;
      load_drv_q <= load_drv_d;
      oen_q      <= oen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
    end
  end

  assign scl_o     = 1'b0;
  assign scl_oen   = 1'b0;
  assign sda_o     = 1'b0;
  assign sda_oen   = oen_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_q;
  assign reg_rd_en = rd_q;
  assign busy      = busy_q;

endmodule
